// File: rtl/vfr_pkg.sv
// vfr_pkg: shared definitions for the VFR frame scheduler.
// Holds the scheduler state encoding, the packet-type codes carried in
// data[3:0] of an encoder output beat, and the configuration record that
// is copied from the shadow registers to the active registers.
package vfr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LATCH     = 3'd1,
    ST_CTRL      = 3'd2,
    ST_CTRL_WAIT = 3'd3,
    ST_VIDEO     = 3'd4,
    ST_DONE      = 3'd5
  } vfr_state_e;

  localparam logic [3:0] CTRL_TYPE  = 4'hF;
  localparam logic [3:0] VIDEO_TYPE = 4'h0;

  typedef struct packed {
    logic [15:0] width;
    logic [15:0] height;
    logic [3:0]  interlaced;
  } vfr_cfg_t;

endpackage

// File: rtl/vfr_packet_monitor.sv
// vfr_packet_monitor: watches the encoder output stream and flags the end
// of control and video packets.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   arm                 1 = tracking enabled; 0 = forget any open packet
//   mon_valid/ready     handshake; a beat is valid & ready together
//   mon_sop/eop         packet delimiters on a beat
//   mon_type            data[3:0] of the beat; meaningful on the sop beat
//   ctrl_end            one-cycle flag: eop beat of a packet whose sop type was CTRL_TYPE
//   video_end           one-cycle flag: eop beat of a packet whose sop type was VIDEO_TYPE
module vfr_packet_monitor
  import vfr_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       arm,
  input  logic       mon_valid,
  input  logic       mon_ready,
  input  logic       mon_sop,
  input  logic       mon_eop,
  input  logic [3:0] mon_type,
  output logic       ctrl_end,
  output logic       video_end
);

  logic       beat;
  logic       in_pkt_q;
  logic [3:0] pkt_type_q;
  logic [3:0] cur_type;
  logic       pkt_open;
  logic       end_beat;

  assign beat = mon_valid & mon_ready;

  // A sop+eop beat is a complete packet on its own, so the type is taken
  // from the beat itself rather than from the stored sop type.
  always_comb begin
    cur_type = mon_sop ? mon_type : pkt_type_q;
    pkt_open = mon_sop | in_pkt_q;
  end

  assign end_beat  = arm & beat & mon_eop & pkt_open;
  assign ctrl_end  = end_beat & (cur_type == CTRL_TYPE);
  assign video_end = end_beat & (cur_type == VIDEO_TYPE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_pkt_q   <= 1'b0;
      pkt_type_q <= 4'h0;
    end else if (!arm) begin
      in_pkt_q   <= 1'b0;
    end else if (beat) begin
      if (mon_sop) begin
        pkt_type_q <= mon_type;
      end
      if (mon_eop) begin
        in_pkt_q <= 1'b0;
      end else if (mon_sop) begin
        in_pkt_q <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/vfr_frame_scheduler.sv
// vfr_frame_scheduler: sequences one control packet and one video packet
// per frame, applying buffered configuration only at frame boundaries.
//
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   cfg_wr                             strobe: load cfg_* into the shadow registers
//   cfg_width/height/interlaced        configuration values
//   cfg_go                             level: run frames continuously
//   do_control_packet                  one-cycle request to the control packet encoder
//   width/height/interlaced            active frame parameters to the encoder
//   reader_start                       one-cycle pulse starting the frame reader
//   mon_valid/ready/sop/eop/type       encoder output stream, monitored only
//   busy                               registered, high when not IDLE
//   cfg_pending                        registered, shadow not yet applied
//   frame_count                        completed frames, wraps
//   frame_irq                          one-cycle pulse per completed frame
//
// state      | meaning
// IDLE       | waiting for cfg_go
// LATCH      | copy shadow config to active registers (1 cycle)
// CTRL       | request control packet (1 cycle)
// CTRL_WAIT  | waiting for end of the control packet
// VIDEO      | reader running; waiting for end of the video packet
// DONE       | frame complete: count, interrupt (1 cycle)
module vfr_frame_scheduler
  import vfr_pkg::*;
#(
  parameter int FRAME_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_wr,
  input  logic [15:0]            cfg_width,
  input  logic [15:0]            cfg_height,
  input  logic [3:0]             cfg_interlaced,
  input  logic                   cfg_go,
  output logic                   do_control_packet,
  output logic [15:0]            width,
  output logic [15:0]            height,
  output logic [3:0]             interlaced,
  output logic                   reader_start,
  input  logic                   mon_valid,
  input  logic                   mon_ready,
  input  logic                   mon_sop,
  input  logic                   mon_eop,
  input  logic [3:0]             mon_type,
  output logic                   busy,
  output logic                   cfg_pending,
  output logic [FRAME_CNT_W-1:0] frame_count,
  output logic                   frame_irq
);

  vfr_state_e             state_q, state_d;
  vfr_cfg_t               shadow_q, active_q;
  logic                   pending_q;
  logic                   do_ctrl_q, reader_start_q, irq_q, busy_q;
  logic [FRAME_CNT_W-1:0] count_q;
  logic                   arm, ctrl_end, video_end;

  // Packet tracking only runs while a frame is waiting on the encoder, so
  // a sop seen before CTRL_WAIT can never complete a control packet.
  assign arm = (state_q == ST_CTRL_WAIT) || (state_q == ST_VIDEO);

  vfr_packet_monitor u_monitor (
    .clk       (clk),
    .rst_n     (rst_n),
    .arm       (arm),
    .mon_valid (mon_valid),
    .mon_ready (mon_ready),
    .mon_sop   (mon_sop),
    .mon_eop   (mon_eop),
    .mon_type  (mon_type),
    .ctrl_end  (ctrl_end),
    .video_end (video_end)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (cfg_go) state_d = ST_LATCH;
      ST_LATCH:     state_d = ST_CTRL;
      ST_CTRL:      state_d = ST_CTRL_WAIT;
      ST_CTRL_WAIT: if (ctrl_end) state_d = ST_VIDEO;
      ST_VIDEO:     if (video_end) state_d = ST_DONE;
      ST_DONE:      state_d = cfg_go ? ST_LATCH : ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so each pulse lines up
  // exactly with the state it belongs to, with no input-to-output path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      do_ctrl_q      <= 1'b0;
      reader_start_q <= 1'b0;
      irq_q          <= 1'b0;
      busy_q         <= 1'b0;
      count_q        <= '0;
    end else begin
      state_q        <= state_d;
      do_ctrl_q      <= (state_d == ST_CTRL);
      reader_start_q <= (state_d == ST_VIDEO) && (state_q != ST_VIDEO);
      irq_q          <= (state_d == ST_DONE);
      busy_q         <= (state_d != ST_IDLE);
      if (state_d == ST_DONE) begin
        count_q <= count_q + FRAME_CNT_W'(1);
      end
    end
  end

  // A write landing in LATCH goes to the shadow only; the active copy
  // takes the old shadow and the pending flag stays set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q  <= '0;
      active_q  <= '0;
      pending_q <= 1'b0;
    end else begin
      if (cfg_wr) begin
        shadow_q <= '{width: cfg_width, height: cfg_height, interlaced: cfg_interlaced};
      end
      if (state_q == ST_LATCH) begin
        active_q <= shadow_q;
      end
      if (cfg_wr) begin
        pending_q <= 1'b1;
      end else if (state_q == ST_LATCH) begin
        pending_q <= 1'b0;
      end
    end
  end

  assign do_control_packet = do_ctrl_q;
  assign reader_start      = reader_start_q;
  assign frame_irq         = irq_q;
  assign busy              = busy_q;
  assign cfg_pending       = pending_q;
  assign frame_count       = count_q;
  assign width             = active_q.width;
  assign height            = active_q.height;
  assign interlaced        = active_q.interlaced;

endmodule

// File: tb/tb_vfr_frame_scheduler.sv
// Bench for vfr_frame_scheduler: a table of frames, hand-built corner
// sequences, then randomized frames against a frame-level model.
module tb_vfr_frame_scheduler;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, cfg_wr, cfg_go;
  logic [15:0] cfg_width, cfg_height;
  logic [3:0]  cfg_interlaced, mon_type;
  logic        mon_valid, mon_ready, mon_sop, mon_eop;

  logic        do_control_packet, reader_start, busy, cfg_pending, frame_irq;
  logic [15:0] width, height, frame_count;
  logic [3:0]  interlaced;

  logic        dcp2, rs2, busy2, pend2, irq2;
  logic [15:0] width2, height2;
  logic [3:0]  il2;
  logic [1:0]  fc2;

  vfr_frame_scheduler dut (
    .clk(clk), .rst_n(rst_n), .cfg_wr(cfg_wr), .cfg_width(cfg_width),
    .cfg_height(cfg_height), .cfg_interlaced(cfg_interlaced), .cfg_go(cfg_go),
    .do_control_packet(do_control_packet), .width(width), .height(height),
    .interlaced(interlaced), .reader_start(reader_start),
    .mon_valid(mon_valid), .mon_ready(mon_ready), .mon_sop(mon_sop),
    .mon_eop(mon_eop), .mon_type(mon_type), .busy(busy),
    .cfg_pending(cfg_pending), .frame_count(frame_count), .frame_irq(frame_irq)
  );

  vfr_frame_scheduler #(.FRAME_CNT_W(2)) dut_w2 (
    .clk(clk), .rst_n(rst_n), .cfg_wr(cfg_wr), .cfg_width(cfg_width),
    .cfg_height(cfg_height), .cfg_interlaced(cfg_interlaced), .cfg_go(cfg_go),
    .do_control_packet(dcp2), .width(width2), .height(height2),
    .interlaced(il2), .reader_start(rs2),
    .mon_valid(mon_valid), .mon_ready(mon_ready), .mon_sop(mon_sop),
    .mon_eop(mon_eop), .mon_type(mon_type), .busy(busy2),
    .cfg_pending(pend2), .frame_count(fc2), .frame_irq(irq2)
  );

  int total = 0;
  int bad = 0;
  int irq_cnt = 0, dcp_cnt = 0, rs_cnt = 0;
  int exp_irq = 0, exp_dcp = 0, exp_rs = 0;
  int frames_done = 0;

  always @(negedge clk) begin
    if (frame_irq) irq_cnt++;
    if (do_control_packet) dcp_cnt++;
    if (reader_start) rs_cnt++;
  end

  typedef struct {
    logic [15:0] w;
    logic [15:0] h;
    logic [3:0]  il;
    bit          bp;
    int          vbeats;
    bit          foreign;
    int          exp_cnt16;
    int          exp_cnt2;
  } vec_t;

  vec_t tbl [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mon_idle();
    mon_valid = 1'b0; mon_sop = 1'b0; mon_eop = 1'b0; mon_type = 4'h0; mon_ready = 1'b1;
  endtask

  // Drives one packet; with bp set, ready toggles randomly while valid stays high.
  task automatic send_pkt(input logic [3:0] typ, input int nbeats, input bit bp);
    int  tries;
    bit  acc;
    for (int i = 0; i < nbeats; i++) begin
      tries = 0;
      acc = 1'b0;
      mon_valid = 1'b1;
      mon_sop   = (i == 0);
      mon_eop   = (i == nbeats - 1);
      mon_type  = (i == 0) ? typ : 4'($urandom);
      while (!acc) begin
        mon_ready = (!bp || tries >= 20) ? 1'b1 : 1'($urandom_range(0, 1));
        tick();
        tries++;
        acc = mon_ready;
      end
    end
    mon_idle();
  endtask

  task automatic wait_dcp();
    int n;
    n = 0;
    while (!do_control_packet && n < 40) begin
      tick();
      n++;
    end
    chk("dcp_seen", 32'(do_control_packet), 1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_dcp"},   32'(do_control_packet), 0);
    chk({tag, "_rs"},    32'(reader_start), 0);
    chk({tag, "_irq"},   32'(frame_irq), 0);
    chk({tag, "_busy"},  32'(busy), 0);
    chk({tag, "_pend"},  32'(cfg_pending), 0);
    chk({tag, "_cnt"},   32'(frame_count), 0);
    chk({tag, "_cfg"},   {12'(0), width ^ height, interlaced}, 0);
    chk({tag, "_w2"},    {16'(0), dcp2, rs2, irq2, busy2, pend2, fc2, il2, 5'(0)}, 0);
    chk({tag, "_w2cfg"}, {width2, height2}, 0);
  endtask

  // One complete frame, starting anywhere before its CTRL cycle and
  // ending one cycle after DONE.
  task automatic run_frame(input logic [15:0] ew, input logic [15:0] eh, input logic [3:0] ei,
                           input bit epend, input bit bp, input int vbeats, input bit foreign,
                           input bit wr_mid, input logic [15:0] nw, input logic [15:0] nh,
                           input logic [3:0] ni, input bit drop_go);
    wait_dcp();
    exp_dcp++;
    chk("ctrl_width", 32'(width), 32'(ew));
    chk("ctrl_height", 32'(height), 32'(eh));
    chk("ctrl_il", 32'(interlaced), 32'(ei));
    chk("ctrl_pend", 32'(cfg_pending), 32'(epend));
    chk("w2_cfg", {width2 ^ height2, 12'(0), il2}, {ew ^ eh, 12'(0), ei});
    tick();
    chk("dcp_one_cycle", 32'(do_control_packet), 0);
    if (drop_go) cfg_go = 1'b0;
    if (foreign) begin
      send_pkt(4'h0, 2, bp);
      chk("no_start_on_video_in_ctrlwait", 32'(reader_start), 0);
      chk("busy_ctrlwait", 32'(busy), 1);
    end
    repeat ($urandom_range(0, 2)) tick();
    send_pkt(4'hF, 1 + $urandom_range(0, 2), bp);
    chk("reader_start", 32'(reader_start), 1);
    exp_rs++;
    if (wr_mid) begin
      cfg_wr = 1'b1; cfg_width = nw; cfg_height = nh; cfg_interlaced = ni;
    end
    tick();
    cfg_wr = 1'b0;
    chk("rs_one_cycle", 32'(reader_start), 0);
    if (wr_mid) begin
      chk("pend_mid", 32'(cfg_pending), 1);
      chk("width_hold", 32'(width), 32'(ew));
    end
    if (foreign) begin
      send_pkt(4'h3, 2, bp);
      send_pkt(4'h7, 1, bp);
      send_pkt(4'hF, 1, bp);
      mon_valid = 1'b0; mon_ready = 1'b1; mon_sop = 1'b1; mon_eop = 1'b1; mon_type = 4'h0;
      tick();
      mon_idle();
      tick();
      chk("busy_after_foreign", 32'(busy), 1);
      chk("no_irq_foreign", 32'(irq_cnt), 32'(exp_irq));
    end
    send_pkt(4'h0, vbeats, bp);
    frames_done++;
    exp_irq++;
    chk("frame_irq", 32'(frame_irq), 1);
    chk("w2_irq", 32'(irq2), 1);
    chk("frame_count", 32'(frame_count), 32'(frames_done % 65536));
    chk("w2_count", 32'(fc2), 32'(frames_done % 4));
    tick();
    chk("irq_one_cycle", 32'(frame_irq), 0);
  endtask

  logic [15:0] sh_w, sh_h, nw, nh;
  logic [3:0]  sh_i, ni;
  bit          wr;

  initial begin
    tbl[0] = '{16'd640,  16'd480,  4'h0, 1'b0, 1, 1'b0, 1, 1};
    tbl[1] = '{16'd1280, 16'd720,  4'h0, 1'b1, 3, 1'b0, 2, 2};
    tbl[2] = '{16'd1920, 16'd1080, 4'h1, 1'b1, 2, 1'b1, 3, 3};
    tbl[3] = '{16'd320,  16'd240,  4'hA, 1'b0, 4, 1'b1, 4, 0};
    tbl[4] = '{16'd800,  16'd600,  4'h5, 1'b1, 1, 1'b0, 5, 1};

    rst_n = 1'b0; cfg_wr = 1'b0; cfg_go = 1'b0;
    cfg_width = 16'h0; cfg_height = 16'h0; cfg_interlaced = 4'h0;
    mon_idle();
    #12;
    chk_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();

    cfg_wr = 1'b1; cfg_width = tbl[0].w; cfg_height = tbl[0].h; cfg_interlaced = tbl[0].il;
    tick();
    cfg_wr = 1'b0;
    chk("pend_after_wr", 32'(cfg_pending), 1);
    chk("active_not_yet", 32'(width), 0);
    cfg_go = 1'b1;

    for (int k = 0; k < 5; k++) begin
      if (k < 4)
        run_frame(tbl[k].w, tbl[k].h, tbl[k].il, 1'b0, tbl[k].bp, tbl[k].vbeats, tbl[k].foreign,
                  1'b1, tbl[k+1].w, tbl[k+1].h, tbl[k+1].il, 1'b0);
      else
        run_frame(tbl[k].w, tbl[k].h, tbl[k].il, 1'b0, tbl[k].bp, tbl[k].vbeats, tbl[k].foreign,
                  1'b1, 16'd555, 16'd444, 4'h6, 1'b0);
      chk("tbl_cnt16", 32'(frame_count), 32'(tbl[k].exp_cnt16));
      chk("tbl_cnt2", 32'(fc2), 32'(tbl[k].exp_cnt2));
    end

    // Now in LATCH: a write here must land in the shadow only.
    chk("latch_busy", 32'(busy), 1);
    chk("latch_no_dcp", 32'(do_control_packet), 0);
    cfg_wr = 1'b1; cfg_width = 16'd1024; cfg_height = 16'd768; cfg_interlaced = 4'h3;
    tick();
    cfg_wr = 1'b0;
    run_frame(16'd555, 16'd444, 4'h6, 1'b1, 1'b0, 2, 1'b0, 1'b0, 16'd0, 16'd0, 4'h0, 1'b0);
    run_frame(16'd1024, 16'd768, 4'h3, 1'b0, 1'b1, 2, 1'b0, 1'b0, 16'd0, 16'd0, 4'h0, 1'b1);

    chk("stop_idle", 32'(busy), 0);
    repeat (20) tick();
    chk("stop_no_dcp", 32'(dcp_cnt), 32'(exp_dcp));
    chk("stop_still_idle", 32'(busy), 0);

    // Reset while VIDEO has an open type-0 packet.
    cfg_go = 1'b1;
    wait_dcp();
    exp_dcp++;
    tick();
    send_pkt(4'hF, 2, 1'b0);
    chk("rst_seq_rs", 32'(reader_start), 1);
    exp_rs++;
    mon_valid = 1'b1; mon_sop = 1'b1; mon_eop = 1'b0; mon_type = 4'h0; mon_ready = 1'b1;
    tick();
    mon_idle();
    #2;
    rst_n = 1'b0;
    cfg_go = 1'b0;
    #1;
    chk_all_zero("midrst");
    tick();
    tick();
    rst_n = 1'b1;
    frames_done = 0;
    repeat (10) tick();
    chk("post_rst_idle", 32'(busy), 0);
    chk("post_rst_no_dcp", 32'(dcp_cnt), 32'(exp_dcp));
    chk("post_rst_no_irq", 32'(irq_cnt), 32'(exp_irq));
    cfg_go = 1'b1;
    run_frame(16'd0, 16'd0, 4'h0, 1'b0, 1'b0, 1, 1'b0, 1'b0, 16'd0, 16'd0, 4'h0, 1'b0);

    // Random frames: each frame uses the newest config written before it began.
    sh_w = 16'd0; sh_h = 16'd0; sh_i = 4'h0;
    for (int f = 0; f < 25; f++) begin
      wr = 1'($urandom_range(0, 1));
      nw = 16'($urandom); nh = 16'($urandom); ni = 4'($urandom);
      run_frame(sh_w, sh_h, sh_i, 1'b0, 1'($urandom_range(0, 1)), $urandom_range(1, 4),
                1'($urandom_range(0, 1)), wr, nw, nh, ni, 1'b0);
      if (wr) begin
        sh_w = nw; sh_h = nh; sh_i = ni;
      end
    end

    chk("irq_total", 32'(irq_cnt), 32'(exp_irq));
    chk("dcp_total", 32'(dcp_cnt), 32'(exp_dcp));
    chk("rs_total", 32'(rs_cnt), 32'(exp_rs));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
